// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared tag width, result-FIFO entry layout and depth limits for fcvt_ctrl.
package fcvt_pkg;
  localparam int TAG_W_DEF = 6;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 4;
  typedef struct packed {
    logic [31:0]          data;
    logic [TAG_W_DEF-1:0] tag;
  } fifo_entry_t;
  function automatic bit depth_legal(input int d);
    return d == DEPTH_MIN || d == DEPTH_MAX;
  endfunction
endpackage

// File: rtl/fcvt_res_fifo.sv
// fcvt_res_fifo: power-of-two result buffer with simultaneous push/pop and synchronous flush.
module fcvt_res_fifo
  import fcvt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  fifo_entry_t                i_wdata,
  output fifo_entry_t                o_rdata,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop, w_full;
  assign w_full = r_cnt == CW'(DEPTH);
  assign w_pop  = i_pop && r_cnt != '0;
  // DEPTH is a power of two, so pointers wrap modulo DEPTH by overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wp] <= i_wdata;
  end
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && !i_flush && w_full && !w_pop));
endmodule

// File: rtl/fcvt_ctrl.sv
// fcvt_ctrl: issue/writeback control around an external int32-to-float converter.
// FCVT_CTRL_STATS_EN enables the issued/stall statistic counters (tied to zero otherwise).
module fcvt_ctrl
  import fcvt_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEF,
  parameter int DEPTH    = 2,
  parameter int CONV_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      conv_x,
  input  logic [31:0]      conv_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall
);
  localparam int CW = $clog2(DEPTH) + 1;
  if (!depth_legal(DEPTH) || TAG_W != TAG_W_DEF || CONV_LAT < 1 || CONV_LAT > 4) begin : g_bad_cfg
    $error("fcvt_ctrl: illegal DEPTH, TAG_W or CONV_LAT");
  end
  logic [CONV_LAT-1:0] r_vld;
  logic [TAG_W-1:0]    r_tag [CONV_LAT];
  logic [CW-1:0]       w_cnt;
  logic [3:0]          w_occ;
  logic                w_acc, w_push, w_pop;
  fifo_entry_t         w_wdata, w_head;
  assign conv_x = in_data;
  // Occupancy counts in-flight ops so the FIFO always has room when they land
  always_comb begin
    w_occ = 4'(w_cnt);
    for (int i = 0; i < CONV_LAT; i++) w_occ = w_occ + 4'(r_vld[i]);
  end
  assign in_ready  = !rst && !flush && w_occ < 4'(DEPTH);
  assign w_acc     = in_valid && in_ready;
  assign w_push    = r_vld[CONV_LAT-1] && !flush;
  assign out_valid = w_cnt != '0;
  assign w_pop     = out_valid && out_ready;
  assign busy      = |r_vld || out_valid;
  assign w_wdata   = '{data: conv_res, tag: r_tag[CONV_LAT-1]};
  assign out_data  = w_head.data;
  assign out_tag   = w_head.tag;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld <= '0;
    else if (flush) r_vld <= '0;
    else begin
      r_vld[0] <= w_acc;
      for (int i = 1; i < CONV_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end
  always_ff @(posedge clk) begin
    r_tag[0] <= in_tag;
    for (int i = 1; i < CONV_LAT; i++) r_tag[i] <= r_tag[i-1];
  end
  fcvt_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_cnt)
  );
`ifdef FCVT_CTRL_STATS_EN
  logic [31:0] r_stat_issued, r_stat_stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      r_stat_issued <= r_stat_issued + 32'(w_acc);
      r_stat_stall  <= r_stat_stall + 32'(out_valid && !out_ready);
    end
  end
  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`else
  assign stat_issued = 32'b0;
  assign stat_stall  = 32'b0;
`endif
endmodule

// File: tb/tb_fcvt_ctrl.sv
// tb_fcvt_ctrl: directed table-driven bench for fcvt_ctrl with a behavioural int-to-float converter.
module tb_fcvt_ctrl;
  localparam int DEPTH = 2;
  localparam int CL    = 1;
  localparam int TW    = 6;
  logic clk, rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] in_data, conv_x, conv_res, out_data, stat_issued, stat_stall;
  logic [TW-1:0] in_tag, out_tag;
  fcvt_ctrl #(.TAG_W(TW), .DEPTH(DEPTH), .CONV_LAT(CL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_tag(in_tag), .flush(flush), .conv_x(conv_x), .conv_res(conv_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .stat_issued(stat_issued), .stat_stall(stat_stall)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic s;
    logic [31:0] m;
    logic [63:0] mant, rem, half, e;
    int p, sh;
    if (x == 0) return 32'h0;
    s = x[31];
    m = s ? -x : x;
    p = 31;
    while (!m[p]) p--;
    if (p <= 23) mant = 64'(m) << (23 - p);
    else begin
      sh   = p - 23;
      mant = 64'(m) >> sh;
      rem  = 64'(m) & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
    end
    e = (64'(127 + p) << 23) + mant - (64'd1 << 23);
    return {s, e[30:0]};
  endfunction
  logic [31:0] cpipe [CL];
  always @(posedge clk) begin
    cpipe[0] <= i2f(conv_x);
    for (int i = 1; i < CL; i++) cpipe[i] <= cpipe[i-1];
  end
  assign conv_res = cpipe[CL-1];
  typedef struct { logic [31:0] d; logic [TW-1:0] t; } exp_t;
  typedef struct { logic [31:0] din; logic [TW-1:0] tag; logic [31:0] dexp; } vec_t;
  exp_t exp_q[$];
  vec_t vecs[10];
  int checks = 0, failures = 0, n_acc = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] d, input logic [TW-1:0] t, input logic [31:0] e);
    bit done = 0;
    in_valid = 1; in_data = d; in_tag = t;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back('{e, t});
        n_acc++;
        done = 1;
      end
      tick();
    end
    in_valid = 0;
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("stale_result", out_data, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_out_data", out_data, e.d);
        chk("mon_out_tag", 32'(out_tag), 32'(e.t));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0] = '{32'h00000000, 6'd1,  32'h00000000};
    vecs[1] = '{32'hFFFFFFFF, 6'd2,  32'hBF800000};
    vecs[2] = '{32'h7FFFFFFF, 6'd3,  32'h4F000000};
    vecs[3] = '{32'h00000002, 6'd4,  32'h40000000};
    vecs[4] = '{32'hFFFFFFFE, 6'd5,  32'hC0000000};
    vecs[5] = '{32'h00FFFFFF, 6'd6,  32'h4B7FFFFF};
    vecs[6] = '{32'h80000000, 6'd7,  32'hCF000000};
    vecs[7] = '{32'h00000003, 6'd8,  32'h40400000};
    vecs[8] = '{32'h0000000A, 6'd9,  32'h41200000};
    vecs[9] = '{32'h01000001, 6'd10, 32'h4B800000};
    rst = 1; in_valid = 0; in_data = 0; in_tag = 0; flush = 0; out_ready = 0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stat_issued", stat_issued, 32'd0);
    chk("rst_stat_stall", stat_stall, 32'd0);
    rst = 0;
    #1 chk("ready_after_rst", 32'(in_ready), 32'd1);
    tick();
    // single op: result visible two cycles after issue
    out_ready = 1; in_valid = 1; in_data = 32'h1; in_tag = 6'd5;
    #1 chk("lat_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{32'h3F800000, 6'd5});
    n_acc++;
    tick();
    in_valid = 0;
    chk("lat_e1_out_valid", 32'(out_valid), 32'd0);
    chk("lat_e1_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_e2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_e2_out_data", out_data, 32'h3F800000);
    chk("lat_e2_out_tag", 32'(out_tag), 32'd5);
    tick();
    chk("lat_e3_out_valid", 32'(out_valid), 32'd0);
    chk("lat_e3_busy", 32'(busy), 32'd0);
    foreach (vecs[i]) issue(vecs[i].din, vecs[i].tag, vecs[i].dexp);
    drain();
    chk("table_idle_busy", 32'(busy), 32'd0);
`ifdef FCVT_CTRL_STATS_EN
    chk("stat_issued", stat_issued, 32'(n_acc));
`else
    chk("stat_issued_tied", stat_issued, 32'd0);
    chk("stat_stall_tied", stat_stall, 32'd0);
`endif
    // backpressure fills the FIFO and holds the head
    out_ready = 0;
    issue(32'd7, 6'd1, 32'h40E00000);
    issue(32'd8, 6'd2, 32'h41000000);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1; in_data = 32'd9; in_tag = 6'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_hold_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_data", out_data, 32'h40E00000);
      chk("stall_hold_tag", 32'(out_tag), 32'd1);
    end
    // full with pop and new op in the same cycle: accept only next cycle
    out_ready = 1;
    #1 chk("full_pop_no_accept", 32'(in_ready), 32'd0);
    tick();
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{32'h41100000, 6'd3});
    n_acc++;
    tick();
    in_valid = 0;
    drain();
    chk("drained_in_ready", 32'(in_ready), 32'd1);
    chk("drained_out_valid", 32'(out_valid), 32'd0);
    // flush with one op buffered and one in flight
    out_ready = 0;
    issue(32'd10, 6'd4, 32'h41200000);
    issue(32'd11, 6'd6, 32'h41300000);
    flush = 1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 0;
    exp_q.delete();
    chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    chk("post_flush_busy", 32'(busy), 32'd0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_flush_no_stale", 32'(out_valid), 32'd0);
    end
    // reset in the middle of a stall, with an op offered while reset rises
    out_ready = 0;
    issue(32'hFFFFFFFE, 6'd7, 32'hC0000000);
    issue(32'd3, 6'd8, 32'h40400000);
    tick(); tick();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1; in_data = 32'd5; in_tag = 6'd9;
    rst = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_stat_stall", stat_stall, 32'd0);
    chk("midrst_stat_issued", stat_issued, 32'd0);
    exp_q.delete();
    tick(); tick();
    in_valid = 0;
    rst = 0;
    #1 chk("rerelease_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_result", 32'(out_valid), 32'd0);
    end
    chk("post_rst_busy", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
